// File: rtl/button_debounce_repeat.sv
// rtl/button_debounce_repeat.sv - debounce and auto-repeat conditioner for an active-low push-button
//
// Ports:
//   clk        system clock, all state on the rising edge
//   resetn     asynchronous active-low reset
//   pb         raw button pin, asynchronous, 0 = pressed
//   pb_state   debounced level, 1 = pressed
//   pb_down    one-cycle pulse when pb_state first shows 1
//   pb_up      one-cycle pulse when pb_state first shows 0
//   pb_repeat  one-cycle pulse on press and on every auto-repeat tick

module button_debounce_repeat #(
   parameter int DEBOUNCE_CYCLES = 65536,
   parameter int REPEAT_EN       = 1,
   parameter int REPEAT_DELAY    = 8000000,
   parameter int REPEAT_RATE     = 1600000
) (
   input  logic clk,
   input  logic resetn,
   input  logic pb,
   output logic pb_state,
   output logic pb_down,
   output logic pb_up,
   output logic pb_repeat
);

   localparam int            DW      = $clog2(DEBOUNCE_CYCLES);
   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DELAY  = 2'd1,
      ST_REPEAT = 2'd2
   } rep_state_e;

   logic          sync1_q;
   logic          sync2_q;
   logic          pressed_s;
   logic [DW-1:0] db_cnt_q;
   logic [DW-1:0] db_cnt_d;
   logic          pb_state_q;
   logic          pb_state_d;
   logic          pb_down_q;
   logic          pb_down_d;
   logic          pb_up_q;
   logic          pb_up_d;

   // Synchroniser flops reset to the released level so a held button after
   // reset is seen as a fresh press once the pipeline refills.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= pb;
         sync2_q <= sync1_q;
      end
   end

   assign pressed_s = ~sync2_q;

   // Counter only runs while the synchronised level disagrees with the
   // debounced level; any agreement (a glitch back) clears it. The toggle
   // edge also produces the press/release event, which drives both the
   // edge pulses and the repeat FSM in the same cycle.
   always_comb begin
      db_cnt_d   = '0;
      pb_state_d = pb_state_q;
      pb_down_d  = 1'b0;
      pb_up_d    = 1'b0;
      if (pressed_s != pb_state_q) begin
         if (db_cnt_q == DB_LAST) begin
            pb_state_d = pressed_s;
            pb_down_d  = pressed_s;
            pb_up_d    = ~pressed_s;
         end else begin
            db_cnt_d = db_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         db_cnt_q   <= '0;
         pb_state_q <= 1'b0;
         pb_down_q  <= 1'b0;
         pb_up_q    <= 1'b0;
      end else begin
         db_cnt_q   <= db_cnt_d;
         pb_state_q <= pb_state_d;
         pb_down_q  <= pb_down_d;
         pb_up_q    <= pb_up_d;
      end
   end

   assign pb_state = pb_state_q;
   assign pb_down  = pb_down_q;
   assign pb_up    = pb_up_q;

   generate
      if (REPEAT_EN != 0) begin : g_repeat
         localparam int            RMAX       = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
         localparam int            RW         = $clog2(RMAX + 1);
         localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
         localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

         rep_state_e    state_q;
         logic [RW-1:0] rc_q;
         logic          pb_repeat_q;

         // Release is tested before the tick compare so a coinciding tick is
         // swallowed and the FSM goes straight back to idle.
         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
               state_q     <= ST_IDLE;
               rc_q        <= '0;
               pb_repeat_q <= 1'b0;
            end else begin
               pb_repeat_q <= 1'b0;
               case (state_q)
                  ST_IDLE: begin
                     if (pb_down_d) begin
                        state_q     <= ST_DELAY;
                        rc_q        <= '0;
                        pb_repeat_q <= 1'b1;
                     end
                  end
                  ST_DELAY: begin
                     if (pb_up_d) begin
                        state_q <= ST_IDLE;
                        rc_q    <= '0;
                     end else if (rc_q == DELAY_LAST) begin
                        state_q     <= ST_REPEAT;
                        rc_q        <= '0;
                        pb_repeat_q <= 1'b1;
                     end else begin
                        rc_q <= rc_q + 1'b1;
                     end
                  end
                  ST_REPEAT: begin
                     if (pb_up_d) begin
                        state_q <= ST_IDLE;
                        rc_q    <= '0;
                     end else if (rc_q == RATE_LAST) begin
                        rc_q        <= '0;
                        pb_repeat_q <= 1'b1;
                     end else begin
                        rc_q <= rc_q + 1'b1;
                     end
                  end
                  default: begin
                     state_q <= ST_IDLE;
                     rc_q    <= '0;
                  end
               endcase
            end
         end

         assign pb_repeat = pb_repeat_q;
      end else begin : g_no_repeat
         assign pb_repeat = pb_down_q;
      end
   endgenerate

endmodule
